// File: rtl/decode_dga_pfifo_ctl_if.sv
// Handshake/status bundle between the DGA panel FIFO controller and its surroundings.
// Optional AFULN signal present only when DECODE_PFIFO_AFULL_EN is defined.
interface decode_dga_pfifo_ctl_if #(
   parameter int AW = 4
);
   logic          i_flushn;
   logic          i_ldpancn;
   logic          i_rmmn;
   logic          o_we;
   logic [AW-1:0] o_waddr;
   logic [AW-1:0] o_raddr;
   logic          o_adle;
   logic          o_dvaln;
   logic          o_empn;
   logic          o_fuln;
   logic [AW:0]   o_cnt;
   logic          o_ovfn;
`ifdef DECODE_PFIFO_AFULL_EN
   logic          o_afuln;
`endif

   modport master (
      output i_flushn, i_ldpancn, i_rmmn,
      input  o_we, o_waddr, o_raddr, o_adle, o_dvaln, o_empn, o_fuln, o_cnt, o_ovfn
`ifdef DECODE_PFIFO_AFULL_EN
      , input o_afuln
`endif
   );

   modport slave (
      input  i_flushn, i_ldpancn, i_rmmn,
      output o_we, o_waddr, o_raddr, o_adle, o_dvaln, o_empn, o_fuln, o_cnt, o_ovfn
`ifdef DECODE_PFIFO_AFULL_EN
      , output o_afuln
`endif
   );
endinterface

// File: rtl/decode_dga_pfifo_ctl.sv
// DGA panel FIFO sequencer: pointers, occupancy, flags and panel read handshake.
// Optional almost-full flag enabled by defining DECODE_PFIFO_AFULL_EN.
module decode_dga_pfifo_ctl #(
   parameter int DEPTH       = 13,
   parameter int AW          = 4,
   parameter int AFULL_LEVEL = 11
) (
   input logic                   i_clk,
   input logic                   i_clearn,
   decode_dga_pfifo_ctl_if.slave bus
);
   localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] C_LAST  = AW'(DEPTH-1);
`ifdef DECODE_PFIFO_AFULL_EN
   localparam logic [AW:0]   C_AFULL = (AW+1)'(AFULL_LEVEL);
`endif

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_POP  = 2'd2,
      R_HOLD = 2'd3
   } rd_state_t;

   rd_state_t     r_state, w_state_nxt;
   logic [AW-1:0] r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt;
   logic [AW:0]   r_cnt, w_cnt_nxt;
   logic          r_empn, r_fuln, r_ovfn, r_adle, r_dvaln;
   logic          r_sync1, r_sync2, r_sync3, r_req, r_ld_prev;
   logic          w_ld_fall, w_full, w_we, w_pop, w_ovf_set;
`ifdef DECODE_PFIFO_AFULL_EN
   logic          r_afuln;
`endif

   // Write detection, occupancy and pointer next-state
   always_comb begin
      w_ld_fall   = r_ld_prev & ~bus.i_ldpancn;
      w_full      = (r_cnt == C_DEPTH);
      w_we        = w_ld_fall & ~w_full & bus.i_flushn;
      w_ovf_set   = w_ld_fall & w_full & bus.i_flushn;
      w_pop       = (r_state == R_POP);
      w_cnt_nxt   = r_cnt;
      w_waddr_nxt = r_waddr;
      w_raddr_nxt = r_raddr;
      case ({w_we, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + (AW+1)'(1'b1);
         2'b01:   w_cnt_nxt = r_cnt - (AW+1)'(1'b1);
         default: w_cnt_nxt = r_cnt;
      endcase
      if (w_we) begin
         w_waddr_nxt = (r_waddr == C_LAST) ? {AW{1'b0}} : r_waddr + AW'(1'b1);
      end else begin
         w_waddr_nxt = r_waddr;
      end
      if (w_pop) begin
         w_raddr_nxt = (r_raddr == C_LAST) ? {AW{1'b0}} : r_raddr + AW'(1'b1);
      end else begin
         w_raddr_nxt = r_raddr;
      end
   end

   // Panel read FSM next-state; r_sync2 is the synchronized RMMN level
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         R_IDLE: begin
            if (r_req) begin
               w_state_nxt = (r_cnt != {(AW+1){1'b0}}) ? R_POP : R_WAIT;
            end else begin
               w_state_nxt = R_IDLE;
            end
         end
         R_WAIT: begin
            if (r_cnt != {(AW+1){1'b0}}) begin
               w_state_nxt = R_POP;
            end else if (r_sync2) begin
               w_state_nxt = R_IDLE;
            end else begin
               w_state_nxt = R_WAIT;
            end
         end
         R_POP:  w_state_nxt = R_HOLD;
         R_HOLD: begin
            if (r_sync2) begin
               w_state_nxt = R_IDLE;
            end else begin
               w_state_nxt = R_HOLD;
            end
         end
         default: w_state_nxt = R_IDLE;
      endcase
   end

   // Input sampling: flush leaves the pin synchronizer running so a held RMMN
   // cannot look like a fresh request afterwards
   always_ff @(posedge i_clk or negedge i_clearn) begin
      if (!i_clearn) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_sync3   <= 1'b1;
         r_req     <= 1'b0;
         r_ld_prev <= 1'b1;
      end else begin
         r_sync1   <= bus.i_rmmn;
         r_sync2   <= r_sync1;
         r_sync3   <= r_sync2;
         r_req     <= bus.i_flushn ? (r_sync3 & ~r_sync2) : 1'b0;
         r_ld_prev <= bus.i_ldpancn;
      end
   end

   // Sequencing state, pointers and registered flags
   always_ff @(posedge i_clk or negedge i_clearn) begin
      if (!i_clearn) begin
         r_state <= R_IDLE;
         r_waddr <= {AW{1'b0}};
         r_raddr <= {AW{1'b0}};
         r_cnt   <= {(AW+1){1'b0}};
         r_empn  <= 1'b0;
         r_fuln  <= 1'b1;
         r_ovfn  <= 1'b1;
         r_adle  <= 1'b0;
         r_dvaln <= 1'b1;
      end else if (!bus.i_flushn) begin
         r_state <= R_IDLE;
         r_waddr <= {AW{1'b0}};
         r_raddr <= {AW{1'b0}};
         r_cnt   <= {(AW+1){1'b0}};
         r_empn  <= 1'b0;
         r_fuln  <= 1'b1;
         r_ovfn  <= 1'b1;
         r_adle  <= 1'b0;
         r_dvaln <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_waddr <= w_waddr_nxt;
         r_raddr <= w_raddr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_empn  <= (w_cnt_nxt != {(AW+1){1'b0}});
         r_fuln  <= (w_cnt_nxt != C_DEPTH);
         r_ovfn  <= r_ovfn & ~w_ovf_set;
         r_adle  <= (w_state_nxt == R_POP);
         r_dvaln <= (w_state_nxt != R_HOLD);
      end
   end

`ifdef DECODE_PFIFO_AFULL_EN
   // Almost-full flag tracks next-state occupancy like the other flags
   always_ff @(posedge i_clk or negedge i_clearn) begin
      if (!i_clearn) begin
         r_afuln <= 1'b1;
      end else if (!bus.i_flushn) begin
         r_afuln <= 1'b1;
      end else begin
         r_afuln <= (w_cnt_nxt < C_AFULL);
      end
   end
   assign bus.o_afuln = r_afuln;
`endif

   assign bus.o_we    = w_we;
   assign bus.o_waddr = r_waddr;
   assign bus.o_raddr = r_raddr;
   assign bus.o_cnt   = r_cnt;
   assign bus.o_empn  = r_empn;
   assign bus.o_fuln  = r_fuln;
   assign bus.o_ovfn  = r_ovfn;
   assign bus.o_adle  = r_adle;
   assign bus.o_dvaln = r_dvaln;
endmodule

// File: tb/tb_decode_dga_pfifo_ctl.sv
// Directed bench for decode_dga_pfifo_ctl with a per-cycle occupancy/handshake model.
module tb_decode_dga_pfifo_ctl;
   localparam int DEPTH = 13;
   localparam int AW    = 4;
   localparam int AFL   = 11;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_dga_pfifo_ctl_if #(.AW(AW)) bus ();

   decode_dga_pfifo_ctl #(.DEPTH(DEPTH), .AW(AW), .AFULL_LEVEL(AFL)) dut (
      .i_clk    (clk),
      .i_clearn (rst_n),
      .bus      (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: occupancy and pointers as plain integers; the panel request is seen
   // 3 clocks after the pin fall is sampled, a release 2 clocks after it is sampled.
   int   m_cnt = 0, m_wp = 0, m_rp = 0;
   bit   m_ovf = 0, m_prev_ld = 1, m_wait = 0, m_pop = 0, m_hold = 0, m_flushed = 0;
   bit [3:0] m_pins = 4'hF;

   always @(posedge clk) begin
      bit req, rel, wr, popped;
      if (!rst_n) begin
         m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_prev_ld = 1;
         m_wait = 0; m_pop = 0; m_hold = 0; m_flushed = 0; m_pins = 4'hF;
      end else begin
         req    = m_pins[3] && !m_pins[2] && !m_flushed;
         rel    = m_pins[1];
         m_pins = {m_pins[2:0], bus.i_rmmn};
         if (!bus.i_flushn) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0;
            m_wait = 0; m_pop = 0; m_hold = 0; m_flushed = 1;
         end else begin
            m_flushed = 0;
            wr     = m_prev_ld && !bus.i_ldpancn && (m_cnt < DEPTH);
            if (m_prev_ld && !bus.i_ldpancn && m_cnt == DEPTH) m_ovf = 1;
            popped = m_pop;
            if (m_pop) begin
               m_pop = 0; m_hold = 1;
            end else if (m_hold) begin
               if (rel) m_hold = 0;
            end else if (m_wait) begin
               if (m_cnt > 0) begin m_wait = 0; m_pop = 1; end
               else if (rel) m_wait = 0;
            end else if (req) begin
               if (m_cnt > 0) m_pop = 1; else m_wait = 1;
            end
            if (wr)     begin m_cnt++; m_wp = (m_wp + 1) % DEPTH; end
            if (popped) begin m_cnt--; m_rp = (m_rp + 1) % DEPTH; end
         end
      end
      m_prev_ld = bus.i_ldpancn;
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("cnt",   bus.o_cnt,   m_cnt);
         chk("waddr", bus.o_waddr, m_wp);
         chk("raddr", bus.o_raddr, m_rp);
         chk("empn",  bus.o_empn,  (m_cnt != 0));
         chk("fuln",  bus.o_fuln,  (m_cnt != DEPTH));
         chk("ovfn",  bus.o_ovfn,  !m_ovf);
         chk("adle",  bus.o_adle,  m_pop);
         chk("dvaln", bus.o_dvaln, !m_hold);
         chk("we",    bus.o_we,    (m_prev_ld && !bus.i_ldpancn && m_cnt < DEPTH && bus.i_flushn));
`ifdef DECODE_PFIFO_AFULL_EN
         chk("afuln", bus.o_afuln, (m_cnt < AFL));
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wr1(input int exp_wa, input bit exp_we);
      bus.i_ldpancn = 1'b0;
      #1;
      chk("wr_we", bus.o_we, exp_we);
      if (exp_we) chk("wr_waddr", bus.o_waddr, exp_wa);
      tick(1);
      bus.i_ldpancn = 1'b1;
      tick(1);
   endtask

   task automatic wait_dval(input string nm);
      int n = 0;
      while (bus.o_dvaln !== 1'b0 && n < 20) begin
         tick(1);
         n++;
      end
      chk(nm, bus.o_dvaln, 0);
   endtask

   task automatic rd1();
      bus.i_rmmn = 1'b0;
      wait_dval("rd_dvaln");
      bus.i_rmmn = 1'b1;
      tick(3);
   endtask

   task automatic flush1();
      bus.i_flushn = 1'b0;
      tick(1);
      bus.i_flushn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_flushn  = 1'b1;
      bus.i_ldpancn = 1'b1;
      bus.i_rmmn    = 1'b1;
      #12;
      chk("rst_waddr", bus.o_waddr, 0);
      chk("rst_raddr", bus.o_raddr, 0);
      chk("rst_cnt",   bus.o_cnt,   0);
      chk("rst_we",    bus.o_we,    0);
      chk("rst_adle",  bus.o_adle,  0);
      chk("rst_dvaln", bus.o_dvaln, 1);
      chk("rst_empn",  bus.o_empn,  0);
      chk("rst_fuln",  bus.o_fuln,  1);
      chk("rst_ovfn",  bus.o_ovfn,  1);
      #11 rst_n = 1'b1;
      tick(1);

      // Three writes land at 0, 1, 2
      for (int i = 0; i < 3; i++) wr1(i, 1'b1);
      chk("w3_cnt", bus.o_cnt, 3);
      chk("w3_empn", bus.o_empn, 1);
      chk("w3_raddr", bus.o_raddr, 0);
      chk("model_cnt3", m_cnt, 3);

      // ADLE exactly 3 clocks after the sampled RMMN fall
      bus.i_rmmn = 1'b0;
      tick(1); chk("lat_k0", bus.o_adle, 0);
      tick(1); chk("lat_k1", bus.o_adle, 0);
      tick(1); chk("lat_k2", bus.o_adle, 0);
      tick(1); chk("lat_k3", bus.o_adle, 1);
      chk("lat_raddr", bus.o_raddr, 0);
      chk("lat_cnt", bus.o_cnt, 3);
      tick(1);
      chk("pop_cnt", bus.o_cnt, 2);
      chk("pop_raddr", bus.o_raddr, 1);
      chk("pop_dvaln", bus.o_dvaln, 0);
      bus.i_rmmn = 1'b1;
      tick(1); chk("rel_r0", bus.o_dvaln, 0);
      tick(1); chk("rel_r1", bus.o_dvaln, 0);
      tick(1); chk("rel_r2", bus.o_dvaln, 1);

      // Fill to full, then an overflowing write
      flush1();
      chk("fl_cnt", bus.o_cnt, 0);
      for (int i = 0; i < DEPTH; i++) wr1(i, 1'b1);
      chk("full_fuln", bus.o_fuln, 0);
      chk("full_cnt", bus.o_cnt, 13);
      chk("full_waddr", bus.o_waddr, 0);
      wr1(0, 1'b0);
      chk("ovf_ovfn", bus.o_ovfn, 0);
      chk("ovf_cnt", bus.o_cnt, 13);
      tick(3);
      chk("ovf_sticky", bus.o_ovfn, 0);

      // Drain everything, pointers wrap, then two writes at 0 and 1
      for (int i = 0; i < DEPTH; i++) rd1();
      chk("drain_raddr", bus.o_raddr, 0);
      chk("drain_cnt", bus.o_cnt, 0);
      chk("drain_empn", bus.o_empn, 0);
      wr1(0, 1'b1);
      wr1(1, 1'b1);
      chk("wrap_cnt", bus.o_cnt, 2);
      chk("model_wp2", m_wp, 2);
      rd1();
      rd1();
      chk("empty_raddr", bus.o_raddr, 2);

      // Read request while empty waits for data
      bus.i_rmmn = 1'b0;
      tick(4);
      chk("wait_adle", bus.o_adle, 0);
      bus.i_ldpancn = 1'b0;
      tick(1);
      chk("wait_cnt1", bus.o_cnt, 1);
      chk("wait_noadle", bus.o_adle, 0);
      bus.i_ldpancn = 1'b1;
      tick(1);
      chk("wait_adle1", bus.o_adle, 1);
      chk("wait_raddr", bus.o_raddr, 2);
      tick(1);
      chk("wait_cnt0", bus.o_cnt, 0);
      chk("wait_empn", bus.o_empn, 0);
      bus.i_rmmn = 1'b1;
      tick(3);
      chk("wait_dvaln", bus.o_dvaln, 1);

      // Flush while holding a popped byte with CNT=5
      for (int i = 0; i < 6; i++) wr1((3 + i) % DEPTH, 1'b1);
      bus.i_rmmn = 1'b0;
      wait_dval("fl_hold");
      tick(1);
      chk("fl_pre_cnt", bus.o_cnt, 5);
      flush1();
      chk("fl_cnt0", bus.o_cnt, 0);
      chk("fl_empn", bus.o_empn, 0);
      chk("fl_dvaln", bus.o_dvaln, 1);
      chk("fl_ovfn", bus.o_ovfn, 1);
      chk("fl_waddr", bus.o_waddr, 0);
      chk("fl_raddr", bus.o_raddr, 0);
      tick(4);
      chk("fl_noreq", bus.o_adle, 0);
      bus.i_rmmn = 1'b1;
      tick(4);

`ifdef DECODE_PFIFO_AFULL_EN
      for (int i = 0; i < 10; i++) wr1(i, 1'b1);
      chk("af_10", bus.o_afuln, 1);
      wr1(10, 1'b1);
      chk("af_11", bus.o_afuln, 0);
      flush1();
      chk("af_flush", bus.o_afuln, 1);
`endif

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_dga_pfifo_ctl.md
Name: decode_dga_pfifo_ctl

Overview:
- Sequencing controller for the DGA panel FIFO (13 x 8 bit): CPU-side IDB writes via LDPANCN go in, panel-processor reads via RMMN come out.
- Owns write/read pointers, occupancy, flags and the panel read handshake. The storage array is a separate 13x8 register file addressed by this block.
- Sits between DECODE_DGA_COMM (LDPANCN source) and the external panel processor pins (XRMN in; XEMN/XFUN out).

Parameters:
- DEPTH, 13, number of FIFO entries (2..16).
- AW, 4, pointer width; must satisfy 2^AW >= DEPTH.
- AFULL_LEVEL, 11, occupancy at which almost-full asserts (optional feature only).

Ports:
- CLK  in  1  system clock (XCLK domain).
- CLEARN  in  1  async active-low reset.
- FLUSHN  in  1  synchronous active-low flush (driven from CLEAR/MCL path).
- LDPANCN  in  1  write strobe, active low, synchronous to CLK.
- RMMN  in  1  panel read request, active low, asynchronous pin.
- WE  out  1  storage write enable; IDB byte written at WADDR this cycle.
- WADDR  out  AW  write pointer.
- RADDR  out  AW  read pointer (head entry).
- ADLE  out  1  one-cycle latch enable: output register captures storage[RADDR].
- DVALN  out  1  active low: output register holds a valid popped byte.
- EMPN  out  1  active low: FIFO empty.
- FULN  out  1  active low: FIFO full.
- CNT  out  AW+1  occupancy, 0..DEPTH.
- OVFN  out  1  sticky active low: a write was dropped because the FIFO was full.

Behaviour:
- Reset (CLEARN low, async): WADDR=0, RADDR=0, CNT=0, WE=0, ADLE=0, DVALN=1, EMPN=0, FULN=1, OVFN=1, read FSM=R_IDLE, sync flops=1.
- FLUSHN low at a clock edge: same values as reset, next cycle. Flush has priority over any write or read in that cycle.
- Write side:
  - Write on each LDPANCN falling edge (previous sample 1, current 0). Holding LDPANCN low produces exactly one write.
  - If CNT<DEPTH: WE=1 for one cycle, combinational with the detected edge. WADDR and CNT update at the next edge.
  - If CNT==DEPTH: WE stays 0, OVFN goes low and stays low until reset/flush.
- RMMN passes through a 2-flop synchronizer. A read request is the falling edge of the synchronized signal.
- Read FSM states R_IDLE, R_WAIT, R_POP, R_HOLD:
  - R_IDLE: on request, go to R_POP if CNT>0, else R_WAIT.
  - R_WAIT: go to R_POP once CNT>0. If synced RMMN returns high first, go to R_IDLE with no pop.
  - R_POP: one cycle, ADLE=1. RADDR increments and CNT decrements at exit. Then go to R_HOLD.
  - R_HOLD: DVALN=0. On synced RMMN high, DVALN=1 and go to R_IDLE.
  - Pin-to-ADLE latency: 3 clocks after the RMMN fall is sampled.
- Pointer rule: WADDR and RADDR increment modulo DEPTH; DEPTH-1 wraps to 0.
- Write and pop in the same cycle (CNT>0): both take effect and CNT is unchanged. At CNT==DEPTH a same-cycle pop frees no space: the write is dropped and flagged.
- Flags are registered from next-state CNT: EMPN = (CNT!=0), FULN = (CNT!=DEPTH). Both are valid the same cycle CNT updates.
- Reset or flush during R_HOLD: DVALN returns to 1 immediately. A panel still holding RMMN low must release it and re-assert to get a new read.

Optional Feature:
- Macro DECODE_PFIFO_AFULL_EN.
- Defined: adds output AFULN (1 bit, active low, registered), low while CNT >= AFULL_LEVEL. Reset value 1, and 1 after flush.
- Not defined: no AFULN port and no comparator logic; all other behaviour identical.

Test Plan:
- Reset, then 3 writes of 0x11, 0x22, 0x33 -> WE pulses at WADDR 0, 1, 2; CNT=3; EMPN=1; RADDR=0.
- From CNT=3, RMMN low -> ADLE exactly 3 clocks later with RADDR=0. DVALN=0 until RMMN high (then DVALN=1 after sync). CNT=2, RADDR=1.
- 13 writes then a 14th -> FULN=0 after the 13th; no WE on the 14th; OVFN=0 and stays 0; CNT=13.
- Wrap: 13 writes, 13 reads, 2 writes -> WADDR sequence ...12, 0, 1; RADDR wraps 12 to 0; CNT=2.
- Read request while empty, then a write 4 clocks later -> FSM in R_WAIT. Pop happens the cycle after CNT becomes 1; CNT back to 0, EMPN=0.
- FLUSHN low while CNT=5 and DVALN=0 -> next cycle CNT=0, EMPN=0, DVALN=1, OVFN=1, pointers 0. With DECODE_PFIFO_AFULL_EN, AFULN=0 at CNT 11 and 1 after flush.
